// File: rtl/sap2_pkg.sv
// sap2_pkg: control-word bit map, opcode constants and T-state indices for the SAP-II sequencer
package sap2_pkg;
   localparam int PC_OUT   = 0;
   localparam int PC_INC   = 1;
   localparam int PC_LOAD  = 2;
   localparam int MAR_LOAD = 3;
   localparam int MEM_RD   = 4;
   localparam int MEM_WR   = 5;
   localparam int IR_LOAD  = 6;
   localparam int A_LOAD   = 7;
   localparam int A_OUT    = 8;
   localparam int B_LOAD   = 9;
   localparam int B_OUT    = 10;
   localparam int ALU_OUT  = 11;
   localparam int ALU_SUB  = 12;
   localparam int OUT_LOAD = 13;

   localparam logic [7:0] NOP    = 8'h00;
   localparam logic [7:0] MOV_AB = 8'h78;
   localparam logic [7:0] ADD_B  = 8'h80;
   localparam logic [7:0] SUB_B  = 8'h90;
   localparam logic [7:0] MVI_A  = 8'h3E;
   localparam logic [7:0] MVI_B  = 8'h06;
   localparam logic [7:0] LDA    = 8'h3A;
   localparam logic [7:0] STA    = 8'h32;
   localparam logic [7:0] JMP    = 8'hC3;
   localparam logic [7:0] JZ     = 8'hCA;
   localparam logic [7:0] OUT    = 8'hD3;
   localparam logic [7:0] HLT    = 8'h76;

   localparam int T1 = 0;
   localparam int T2 = 1;
   localparam int T3 = 2;
   localparam int T4 = 3;
   localparam int T5 = 4;
   localparam int T6 = 5;
endpackage

// File: rtl/sap2_ctrl_decode.sv
// sap2_ctrl_decode: combinational map of (t, mc, opcode, flag_z) to the control word and sequencing strobes
module sap2_ctrl_decode
   import sap2_pkg::*;
#(
   parameter int OPW = 8,
   parameter int CW  = 14
) (
   input  logic [5:0]     t,
   input  logic           mc,
   input  logic [OPW-1:0] opcode,
   input  logic           flag_z,
   output logic [CW-1:0]  ctrl,
   output logic           done,
   output logic           set_halt,
   output logic           load_flags
);
   logic is_lda, is_sta;

   assign is_lda = opcode == OPW'(LDA);
   assign is_sta = opcode == OPW'(STA);

   always_comb begin
      ctrl       = '0;
      done       = 1'b0;
      set_halt   = 1'b0;
      load_flags = 1'b0;
      // mc1 only carries the LDA/STA memory access; T6 there is the watchdog
      if (mc) begin
         ctrl[MEM_RD] = t[T1] && is_lda;
         ctrl[A_LOAD] = t[T1] && is_lda;
         ctrl[A_OUT]  = t[T1] && is_sta;
         ctrl[MEM_WR] = t[T1] && is_sta;
         done         = (t[T1] && (is_lda || is_sta)) || t[T6];
      end else if (t[T1]) begin
         ctrl[PC_OUT]   = 1'b1;
         ctrl[MAR_LOAD] = 1'b1;
      end else if (t[T2]) begin
         ctrl[PC_INC] = 1'b1;
      end else if (t[T3]) begin
         ctrl[MEM_RD]  = 1'b1;
         ctrl[IR_LOAD] = 1'b1;
      end else if (t[T4]) begin
         case (opcode)
            OPW'(MOV_AB): begin
               ctrl[B_OUT]  = 1'b1;
               ctrl[A_LOAD] = 1'b1;
               done         = 1'b1;
            end
            OPW'(ADD_B), OPW'(SUB_B): begin
               ctrl[ALU_OUT] = 1'b1;
               ctrl[A_LOAD]  = 1'b1;
               ctrl[ALU_SUB] = opcode == OPW'(SUB_B);
               load_flags    = 1'b1;
               done          = 1'b1;
            end
            OPW'(MVI_A), OPW'(MVI_B), OPW'(LDA), OPW'(STA), OPW'(JMP): begin
               ctrl[PC_OUT]   = 1'b1;
               ctrl[MAR_LOAD] = 1'b1;
            end
            OPW'(JZ): begin
               ctrl[PC_OUT]   = flag_z;
               ctrl[MAR_LOAD] = flag_z;
               ctrl[PC_INC]   = !flag_z;
               done           = !flag_z;
            end
            OPW'(OUT): begin
               ctrl[A_OUT]    = 1'b1;
               ctrl[OUT_LOAD] = 1'b1;
               done           = 1'b1;
            end
            OPW'(HLT): set_halt = 1'b1;
            default:   done     = 1'b1;
         endcase
      end else if (t[T5]) begin
         ctrl[PC_INC] = opcode inside {OPW'(MVI_A), OPW'(MVI_B), OPW'(LDA), OPW'(STA)};
      end else if (t[T6]) begin
         ctrl[MEM_RD]   = opcode inside {OPW'(MVI_A), OPW'(MVI_B), OPW'(LDA), OPW'(STA), OPW'(JMP), OPW'(JZ)};
         ctrl[A_LOAD]   = opcode == OPW'(MVI_A);
         ctrl[B_LOAD]   = opcode == OPW'(MVI_B);
         ctrl[MAR_LOAD] = is_lda || is_sta;
         ctrl[PC_LOAD]  = opcode == OPW'(JMP) || opcode == OPW'(JZ);
         done           = !(is_lda || is_sta);
      end
   end
endmodule

// File: rtl/sap2_control_seq.sv
// sap2_control_seq: SAP-II controller-sequencer holding machine cycle, halt and ALU flag state
module sap2_control_seq
   import sap2_pkg::*;
#(
   parameter int OPW = 8,
   parameter int CW  = 14
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [5:0]     t,
   input  logic [OPW-1:0] opcode,
   input  logic           alu_zero,
   input  logic           alu_sign,
   output logic [CW-1:0]  ctrl,
   output logic           ring_clr,
   output logic           halted,
   output logic           flag_z,
   output logic           flag_s,
   output logic           mc
);
   logic [CW-1:0] dec_ctrl;
   logic          done, set_halt, load_flags, active;

   sap2_ctrl_decode #(.OPW(OPW), .CW(CW)) u_decode (
      .t          (t),
      .mc         (mc),
      .opcode     (opcode),
      .flag_z     (flag_z),
      .ctrl       (dec_ctrl),
      .done       (done),
      .set_halt   (set_halt),
      .load_flags (load_flags)
   );

   // Reset, halt or a corrupt ring state all park the ring at T1 with the bus idle
   assign active   = rst && !halted && $onehot(t);
   assign ctrl     = active ? dec_ctrl : '0;
   assign ring_clr = !active || done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mc     <= 1'b0;
         halted <= 1'b0;
         flag_z <= 1'b0;
         flag_s <= 1'b0;
      end else if (active) begin
         mc <= done ? 1'b0 : (mc || t[T6]);
         if (set_halt) halted <= 1'b1;
         if (load_flags) begin
            flag_z <= alu_zero;
            flag_s <= alu_sign;
         end
      end
   end
endmodule
